// File: rtl/prefetch_pingpong_ctrl_if.sv
// Handshake and control bundle between the ping-pong prefetch
// controller (master) and its job source, DMA, buffers and consumer.
interface prefetch_pingpong_ctrl_if;
    logic        job_valid;
    logic        job_ready;
    logic [31:0] job_addr;
    logic [31:0] job_len;
    logic        dma_req;
    logic [31:0] dma_addr;
    logic [12:0] dma_beats;
    logic        dma_ack;
    logic        dma_beat_valid;
    logic        wr_en;
    logic        wr_sel;
    logic [11:0] wr_addr;
    logic [1:0]  wpe;
    logic [1:0]  pe;
    logic [1:0]  pf;
    logic [1:0]  ue;
    logic [1:0]  uf;
    logic        cons_ready;
    logic        cons_sel;
    logic [31:0] cons_addr;
    logic [31:0] cons_len;
    logic        cons_take;
    logic        cons_done;
    logic        len_err;
    logic        busy;

    modport master (
        input  job_valid, job_addr, job_len,
        input  dma_ack, dma_beat_valid,
        input  cons_take, cons_done,
        output job_ready,
        output dma_req, dma_addr, dma_beats,
        output wr_en, wr_sel, wr_addr,
        output wpe, pe, pf, ue, uf,
        output cons_ready, cons_sel, cons_addr, cons_len,
        output len_err, busy
    );

    modport slave (
        output job_valid, job_addr, job_len,
        output dma_ack, dma_beat_valid,
        output cons_take, cons_done,
        input  job_ready,
        input  dma_req, dma_addr, dma_beats,
        input  wr_en, wr_sel, wr_addr,
        input  wpe, pe, pf, ue, uf,
        input  cons_ready, cons_sel, cons_addr, cons_len,
        input  len_err, busy
    );
endinterface

// File: rtl/prefetch_pingpong_ctrl.sv
// Ping-pong sequencer for two prefetch buffers: one buffer is filled
// by DMA while the other is read, blocks handed over in fill order.
module prefetch_pingpong_ctrl #(
    parameter int BEAT_BYTES  = 8,
    parameter int DEPTH_BEATS = 4096
) (
    input logic                      clk,
    input logic                      rst,
    prefetch_pingpong_ctrl_if.master bus
);
    localparam int          SH        = $clog2(BEAT_BYTES);
    localparam logic [31:0] MAX_BYTES = 32'(DEPTH_BEATS * BEAT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_FILL, S_FULL, S_USE
    } buf_st_t;

    typedef enum logic [2:0] {
        F_IDLE, F_ARM, F_SKIP, F_REQ, F_DATA, F_DONE
    } fill_st_t;

    buf_st_t     r_sh [2];
    fill_st_t    r_fs;
    logic        r_fp;
    logic        r_cp;
    logic [31:0] r_addr;
    logic [31:0] r_len;
    logic [12:0] r_beats;
    logic [12:0] r_bc;
    logic [31:0] r_baddr [2];
    logic [31:0] r_blen [2];
    logic [1:0]  r_wpe;
    logic [1:0]  r_pe;
    logic [1:0]  r_pf;
    logic [1:0]  r_ue;
    logic [1:0]  r_uf;
    logic        r_dma_req;
    logic [31:0] r_dma_addr;
    logic [12:0] r_dma_beats;
    logic        r_len_err;

    logic        w_clip;
    logic [31:0] w_rnd;
    logic [12:0] w_beats;
    logic        w_accept;
    logic        w_beat;
    logic        w_last;
    logic        w_done;
    logic        w_take;

    function automatic logic [1:0] oh(input logic s);
        return s ? 2'b10 : 2'b01;
    endfunction

    assign w_clip   = bus.job_len > MAX_BYTES;
    assign w_rnd    = bus.job_len + 32'(BEAT_BYTES - 1);
    assign w_beats  = w_clip ? 13'(DEPTH_BEATS) : 13'(w_rnd >> SH);
    assign w_accept = bus.job_valid && (r_fs == F_IDLE)
                   && (r_sh[r_fp] == S_IDLE);
    assign w_beat   = (r_fs == F_DATA) && bus.dma_beat_valid;
    assign w_last   = r_bc == (r_beats - 13'd1);
    assign w_done   = bus.cons_done && (r_sh[r_cp] == S_USE);
    // a take in the cycle ue is showing would re-pulse the same buffer
    assign w_take   = bus.cons_take && (r_sh[r_cp] == S_FULL)
                   && (r_ue == 2'b00) && !w_done;

    assign bus.job_ready  = w_accept;
    assign bus.dma_req    = r_dma_req;
    assign bus.dma_addr   = r_dma_addr;
    assign bus.dma_beats  = r_dma_beats;
    assign bus.wr_en      = w_beat;
    assign bus.wr_sel     = r_fp;
    assign bus.wr_addr    = r_bc[11:0];
    assign bus.wpe        = r_wpe;
    assign bus.pe         = r_pe;
    assign bus.pf         = r_pf;
    assign bus.ue         = r_ue;
    assign bus.uf         = r_uf;
    assign bus.cons_ready = r_sh[r_cp] == S_FULL;
    assign bus.cons_sel   = r_cp;
    assign bus.cons_addr  = r_baddr[r_cp];
    assign bus.cons_len   = r_blen[r_cp];
    assign bus.len_err    = r_len_err;
    assign bus.busy       = (r_sh[0] != S_IDLE) || (r_sh[1] != S_IDLE)
                         || (r_fs != F_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fs        <= F_IDLE;
            r_fp        <= 1'b0;
            r_cp        <= 1'b0;
            r_addr      <= '0;
            r_len       <= '0;
            r_beats     <= '0;
            r_bc        <= '0;
            r_wpe       <= '0;
            r_pe        <= '0;
            r_pf        <= '0;
            r_ue        <= '0;
            r_uf        <= '0;
            r_dma_req   <= 1'b0;
            r_dma_addr  <= '0;
            r_dma_beats <= '0;
            r_len_err   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_sh[i]    <= S_IDLE;
                r_baddr[i] <= '0;
                r_blen[i]  <= '0;
            end
        end else begin
            r_wpe <= '0;
            r_pe  <= '0;
            r_pf  <= '0;
            r_ue  <= '0;
            r_uf  <= '0;

            // shadow follows the pulse the buffer is sampling now
            for (int i = 0; i < 2; i++) begin
                unique case (1'b1)
                    r_wpe[i]: r_sh[i] <= S_ARMED;
                    r_pe[i]:  r_sh[i] <= S_FILL;
                    r_pf[i]:  r_sh[i] <= S_FULL;
                    r_ue[i]:  r_sh[i] <= S_USE;
                    r_uf[i]:  r_sh[i] <= S_IDLE;
                    default: ;
                endcase
            end

            unique case (r_fs)
                F_IDLE: begin
                    if (w_accept) begin
                        r_addr    <= bus.job_addr;
                        r_len     <= w_clip ? MAX_BYTES : bus.job_len;
                        r_beats   <= w_beats;
                        r_len_err <= r_len_err | w_clip;
                        r_wpe     <= oh(r_fp);
                        r_fs      <= F_ARM;
                    end
                end
                F_ARM: begin
                    r_pe <= oh(r_fp);
                    if (r_beats == 13'd0) begin
                        r_fs <= F_SKIP;
                    end else begin
                        r_dma_req   <= 1'b1;
                        r_dma_addr  <= r_addr;
                        r_dma_beats <= r_beats;
                        r_fs        <= F_REQ;
                    end
                end
                F_SKIP: begin
                    r_pf <= oh(r_fp);
                    r_fs <= F_DONE;
                end
                F_REQ: begin
                    if (bus.dma_ack) begin
                        r_dma_req <= 1'b0;
                        r_bc      <= '0;
                        r_fs      <= F_DATA;
                    end
                end
                F_DATA: begin
                    if (w_beat) begin
                        r_bc <= r_bc + 13'd1;
                        if (w_last) begin
                            r_pf <= oh(r_fp);
                            r_fs <= F_DONE;
                        end
                    end
                end
                F_DONE: begin
                    r_baddr[r_fp] <= r_addr;
                    r_blen[r_fp]  <= r_len;
                    r_fp          <= ~r_fp;
                    r_fs          <= F_IDLE;
                end
                default: r_fs <= F_IDLE;
            endcase

            if (w_done) begin
                r_uf <= oh(r_cp);
                r_cp <= ~r_cp;
            end else if (w_take) begin
                r_ue <= oh(r_cp);
            end
        end
    end
endmodule

// File: tb/tb_prefetch_pingpong_ctrl.sv
// Bench for prefetch_pingpong_ctrl: scenario tasks against a queue
// model of accepted blocks and alternating buffer order.
module tb_prefetch_pingpong_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    prefetch_pingpong_ctrl_if bus ();

    prefetch_pingpong_ctrl #(
        .BEAT_BYTES  (8),
        .DEPTH_BEATS (4096)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] l;
    } blk_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   n_cons = 0;
    int   uf0 = 0;
    int   rdy_cyc = 0;
    blk_t q[$];

    logic [138:0] all_out;
    assign all_out = {bus.job_ready, bus.dma_req, bus.dma_addr,
                      bus.dma_beats, bus.wr_en, bus.wr_sel, bus.wr_addr,
                      bus.wpe, bus.pe, bus.pf, bus.ue, bus.uf,
                      bus.cons_ready, bus.cons_sel, bus.cons_addr,
                      bus.cons_len, bus.len_err, bus.busy};

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.job_valid      = 1'b0;
        bus.job_addr       = '0;
        bus.job_len        = '0;
        bus.dma_ack        = 1'b0;
        bus.dma_beat_valid = 1'b0;
        bus.cons_take      = 1'b0;
        bus.cons_done      = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_acc  = 0;
        n_cons = 0;
        q.delete();
        tick();
    endtask

    // Producer: offers one job, answers the DMA and feeds its beats.
    task automatic run_job(input logic [31:0] a, input logic [31:0] l,
                           input int gap, input int abort_at);
        logic [31:0] el;
        logic [12:0] eb;
        logic [1:0]  eoh;
        int          t;
        el  = (l > 32'd32768) ? 32'd32768 : l;
        eb  = 13'((el + 32'd7) / 32'd8);
        eoh = (n_acc % 2 == 1) ? 2'b10 : 2'b01;
        bus.job_addr  = a;
        bus.job_len   = l;
        bus.job_valid = 1'b1;
        #1;
        t = 0;
        while (!bus.job_ready && t < 600) begin
            tick();
            #1;
            t++;
        end
        checks++;
        if (bus.job_ready !== 1'b1) begin
            errors++;
            $display("FAIL job_ready_wait got=%b want=1", bus.job_ready);
            bus.job_valid = 1'b0;
            return;
        end
        rdy_cyc = cyc;
        tick();
        bus.job_valid = 1'b0;
        q.push_back('{a, el});
        n_acc++;
        checks++;
        if ({bus.wpe, bus.pe} !== {eoh, 2'b00}) begin
            errors++;
            $display("FAIL wpe got=%b/%b want=%b/00", bus.wpe, bus.pe, eoh);
        end
        tick();
        checks++;
        if ({bus.pe, bus.wpe, bus.dma_req} !== {eoh, 2'b00, eb != 13'd0}) begin
            errors++;
            $display("FAIL pe got=%b/%b req=%b want=%b/00 req=%b",
                     bus.pe, bus.wpe, bus.dma_req, eoh, eb != 13'd0);
        end
        if (eb != 13'd0) begin
            checks++;
            if ({bus.dma_addr, bus.dma_beats} !== {a, eb}) begin
                errors++;
                $display("FAIL dma_cmd got=%h/%0d want=%h/%0d",
                         bus.dma_addr, bus.dma_beats, a, eb);
            end
            repeat ($urandom_range(0, gap)) begin
                tick();
                checks++;
                if (bus.dma_req !== 1'b1) begin
                    errors++;
                    $display("FAIL dma_req_hold got=%b want=1", bus.dma_req);
                end
            end
            bus.dma_ack = 1'b1;
            tick();
            bus.dma_ack = 1'b0;
            checks++;
            if (bus.dma_req !== 1'b0) begin
                errors++;
                $display("FAIL dma_req_drop got=%b want=0", bus.dma_req);
            end
            for (int k = 0; k < int'(eb); k++) begin
                if (k == abort_at) begin
                    bus.dma_beat_valid = 1'b0;
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    #1;
                    checks++;
                    if (all_out !== '0) begin
                        errors++;
                        $display("FAIL reset_mid got=%h want=0", all_out);
                    end
                    repeat (5) begin
                        bus.dma_beat_valid = 1'b1;
                        #1;
                        checks++;
                        if (bus.wr_en !== 1'b0) begin
                            errors++;
                            $display("FAIL stale_beat wr_en got=%b want=0", bus.wr_en);
                        end
                        tick();
                    end
                    bus.dma_beat_valid = 1'b0;
                    n_acc  = 0;
                    n_cons = 0;
                    q.delete();
                    return;
                end
                repeat ($urandom_range(0, gap)) begin
                    bus.dma_beat_valid = 1'b0;
                    #1;
                    checks++;
                    if (bus.wr_en !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_wr_en got=%b want=0", bus.wr_en);
                    end
                    tick();
                end
                bus.dma_beat_valid = 1'b1;
                #1;
                checks++;
                if ({bus.wr_en, bus.wr_sel, bus.wr_addr} !== {1'b1, eoh[1], 12'(k)}) begin
                    errors++;
                    $display("FAIL write got=%b/%b/%0d want=1/%b/%0d",
                             bus.wr_en, bus.wr_sel, bus.wr_addr, eoh[1], k);
                end
                tick();
            end
            bus.dma_beat_valid = 1'b0;
        end else begin
            tick();
        end
        checks++;
        if ({bus.pf, bus.dma_req} !== {eoh, 1'b0}) begin
            errors++;
            $display("FAIL pf got=%b req=%b want=%b req=0", bus.pf, bus.dma_req, eoh);
        end
        tick();
    endtask

    // Consumer: takes blocks in order, checks them against the model.
    task automatic consume(input int n, input int dmin, input int dmax);
        blk_t       e;
        logic [1:0] soh;
        int         t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!bus.cons_ready && t < 3000) begin
                tick();
                t++;
            end
            checks++;
            if (bus.cons_ready !== 1'b1) begin
                errors++;
                $display("FAIL cons_ready_wait got=%b want=1", bus.cons_ready);
                return;
            end
            repeat ($urandom_range(dmin, dmax)) tick();
            if (q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_block got=%h want=none", bus.cons_addr);
                return;
            end
            e   = q.pop_front();
            soh = (n_cons % 2 == 1) ? 2'b10 : 2'b01;
            checks++;
            if ({bus.cons_ready, bus.cons_sel, bus.cons_addr, bus.cons_len}
                !== {1'b1, soh[1], e.a, e.l}) begin
                errors++;
                $display("FAIL cons_block got=%b/%b/%h/%0d want=1/%b/%h/%0d",
                         bus.cons_ready, bus.cons_sel, bus.cons_addr,
                         bus.cons_len, soh[1], e.a, e.l);
            end
            bus.cons_take = 1'b1;
            tick();
            bus.cons_take = 1'b0;
            checks++;
            if ({bus.ue, bus.uf} !== {soh, 2'b00}) begin
                errors++;
                $display("FAIL ue got=%b/%b want=%b/00", bus.ue, bus.uf, soh);
            end
            repeat (1 + $urandom_range(dmin, dmax)) tick();
            bus.cons_done = 1'b1;
            tick();
            bus.cons_done = 1'b0;
            checks++;
            if ({bus.uf, bus.ue} !== {soh, 2'b00}) begin
                errors++;
                $display("FAIL uf got=%b/%b want=%b/00", bus.uf, bus.ue, soh);
            end
            if (n_cons == 0) uf0 = cyc;
            n_cons++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", all_out);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        run_job(32'h0000_1000, 32'd64, 2, -1);
        checks++;
        if ({bus.cons_ready, bus.cons_sel, bus.cons_addr, bus.cons_len}
            !== {1'b1, 1'b0, 32'h0000_1000, 32'd64}) begin
            errors++;
            $display("FAIL single_offer got=%b/%b/%h/%0d want=1/0/1000/64",
                     bus.cons_ready, bus.cons_sel, bus.cons_addr, bus.cons_len);
        end
        consume(1, 0, 3);
    endtask

    task automatic test_zero();
        do_reset();
        run_job(32'h0000_0500, 32'd0, 0, -1);
        consume(1, 0, 1);
    endtask

    task automatic test_clip();
        do_reset();
        run_job(32'h0000_2000, 32'd40000, 0, -1);
        checks++;
        if (bus.len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_err_set got=%b want=1", bus.len_err);
        end
        consume(1, 0, 2);
        checks++;
        if (bus.len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_err_sticky got=%b want=1", bus.len_err);
        end
    endtask

    task automatic test_pingpong();
        do_reset();
        fork
            begin
                for (int i = 0; i < 3; i++)
                    run_job(32'h0001_0000 + 32'(i * 32'h100), 32'd32, 1, -1);
            end
            consume(3, 25, 30);
        join
        checks++;
        if (rdy_cyc !== uf0 + 1) begin
            errors++;
            $display("FAIL job3_ready_cycle got=%0d want=%0d", rdy_cyc, uf0 + 1);
        end
    endtask

    task automatic test_ignored();
        do_reset();
        bus.cons_take = 1'b1;
        tick();
        bus.cons_take = 1'b0;
        checks++;
        if ({bus.ue, bus.uf, bus.busy, bus.cons_ready} !== 6'b0) begin
            errors++;
            $display("FAIL take_no_ready got=%b/%b/%b/%b want=0",
                     bus.ue, bus.uf, bus.busy, bus.cons_ready);
        end
        bus.cons_done = 1'b1;
        tick();
        bus.cons_done = 1'b0;
        checks++;
        if ({bus.uf, bus.busy} !== 3'b0) begin
            errors++;
            $display("FAIL done_idle got=%b/%b want=00/0", bus.uf, bus.busy);
        end
        run_job(32'h0000_4000, 32'd8, 0, -1);
        void'(q.pop_front());
        bus.cons_done = 1'b1;
        tick();
        bus.cons_done = 1'b0;
        checks++;
        if ({bus.uf, bus.ue, bus.cons_ready} !== 5'b0000_1) begin
            errors++;
            $display("FAIL done_full got=%b/%b/%b want=00/00/1",
                     bus.uf, bus.ue, bus.cons_ready);
        end
        bus.cons_take = 1'b1;
        bus.cons_done = 1'b1;
        tick();
        bus.cons_take = 1'b0;
        bus.cons_done = 1'b0;
        checks++;
        if ({bus.ue, bus.uf} !== 4'b01_00) begin
            errors++;
            $display("FAIL take_with_done got=%b/%b want=01/00", bus.ue, bus.uf);
        end
        tick();
        checks++;
        if (bus.cons_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_use_ready got=%b want=0", bus.cons_ready);
        end
        bus.cons_take = 1'b1;
        bus.cons_done = 1'b1;
        tick();
        bus.cons_take = 1'b0;
        bus.cons_done = 1'b0;
        checks++;
        if ({bus.uf, bus.ue} !== 4'b01_00) begin
            errors++;
            $display("FAIL done_first got=%b/%b want=01/00", bus.uf, bus.ue);
        end
        n_cons++;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_after got=%b want=0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_job(32'h0000_6000, 32'd64, 1, 3);
        run_job(32'h0000_7000, 32'd24, 1, -1);
        consume(1, 0, 2);
    endtask

    task automatic test_random();
        do_reset();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    run_job($urandom, 32'($urandom_range(0, 160)), 2, -1);
            end
            consume(10, 0, 6);
        join
        tick();
        checks++;
        if ({bus.busy, bus.len_err, bus.cons_ready} !== 3'b000) begin
            errors++;
            $display("FAIL random_end got=%b/%b/%b want=0/0/0",
                     bus.busy, bus.len_err, bus.cons_ready);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_single();
        test_zero();
        test_clip();
        test_pingpong();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prefetch_pingpong_ctrl.md
Name: prefetch_pingpong_ctrl

Overview:
- Sequences two prefetch buffer instances (buffer 0 and buffer 1) as a ping-pong pair.
- Accepts block descriptors and drives each buffer's five control pulses (wait-prefetch, prefetch, prefetch-finish, use, use-finish).
- Issues DMA burst requests and steers the 64-bit write beats into the buffer being filled.
- Hands filled buffers to the consumer strictly in fill order, so one buffer is filled while the other is read.

Parameters:
- BEAT_BYTES, 8, bytes per DMA beat (64-bit data).
- DEPTH_BEATS, 4096, buffer capacity in beats (12-bit buffer address).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- job_valid  in  1  descriptor available
- job_ready  out  1  descriptor accepted this cycle
- job_addr  in  32  block start byte address
- job_len  in  32  block length in bytes
- dma_req  out  1  burst request; held until dma_ack
- dma_addr  out  32  burst start address
- dma_beats  out  13  burst length in beats
- dma_ack  in  1  burst accepted
- dma_beat_valid  in  1  one 64-bit beat present
- wr_en  out  1  write strobe to the selected buffer
- wr_sel  out  1  buffer index being filled
- wr_addr  out  12  beat index within the buffer
- wpe  out  2  wait_prefetch_enable pulse; bit i drives buffer i
- pe  out  2  prefetch_enable pulse per buffer
- pf  out  2  prefetch_finish pulse per buffer
- ue  out  2  use_enable pulse per buffer
- uf  out  2  use_finish pulse per buffer
- cons_ready  out  1  filled buffer available to the consumer
- cons_sel  out  1  buffer index offered to the consumer
- cons_addr  out  32  start address of the offered block
- cons_len  out  32  length of the offered block
- cons_take  in  1  consumer starts using the offered buffer
- cons_done  in  1  consumer finished with the buffer in use
- len_err  out  1  sticky flag: a descriptor was clipped
- busy  out  1  any buffer not in IDLE, or fill FSM not in F_IDLE

Behaviour:
- Reset: synchronous, active-high on rst, clock clk.
  - All outputs go to 0.
  - Both shadow states go to IDLE; fill pointer fp=0, consume pointer cp=0; len_err cleared.
  - Reset mid-operation abandons all transfers. Buffers share rst, so both sides return to idle together.
- Shadow state per buffer mirrors the buffer's FSM: IDLE -> ARMED -> FILL -> FULL -> USE -> IDLE. Updates are registered on the edge at which the matching pulse is sampled.
- Every pulse (wpe, pe, pf, ue, uf) is exactly 1 cycle wide, and at most one bit of each vector is set in any cycle.
- Fill FSM:
  - F_IDLE: job_ready = job_valid && shadow[fp]==IDLE (combinational). On accept: latch addr/len, pulse wpe[fp], go to F_ARM.
  - F_ARM: pulse pe[fp]. Compute beats = ceil(len/8). If beats==0, go to F_DONE; otherwise go to F_REQ.
  - F_REQ: dma_req=1 with dma_addr and dma_beats stable until the cycle dma_ack=1, then go to F_DATA with beat counter bc=0.
  - F_DATA: wr_en = dma_beat_valid, wr_sel=fp, wr_addr=bc; bc increments per valid beat. The beat with bc==beats-1 goes to F_DONE. Beats arriving outside F_DATA are ignored (no wr_en).
  - F_DONE: pulse pf[fp] (1 cycle after the last write), set shadow[fp]=FULL, store addr/len for that buffer, toggle fp, go to F_IDLE.
- Length rule: job_len > DEPTH_BEATS*8 is clipped to DEPTH_BEATS beats and sets len_err. cons_len reports the clipped byte count.
- Consume side:
  - cons_ready = shadow[cp]==FULL; cons_sel=cp; cons_addr/cons_len come from the stored values.
  - cons_take while cons_ready: pulse ue[cp] next cycle, shadow USE. cons_take without cons_ready is ignored.
  - cons_done while shadow[cp]==USE: pulse uf[cp] next cycle, shadow IDLE, toggle cp. cons_done in any other state is ignored.
  - cons_take and cons_done in the same cycle: cons_done acts first (finishes the current buffer); cons_take is ignored.
- Simultaneous events:
  - Fill and consume sides run independently on different buffers.
  - wpe for a buffer is never issued in the same cycle as, or before, its uf pulse. This holds because shadow IDLE is visible only on the following cycle.
- Ordering: blocks are delivered to the consumer in acceptance order. With both buffers FULL, job_ready stays 0 until a uf occurs.

Test Plan:
- Single block, job_addr=0x1000, job_len=64 -> wpe=01, then pe=01, then dma_req with dma_beats=8; 8 beats give wr_addr 0..7 with wr_sel=0; pf=01 one cycle after the last beat; cons_ready=1, cons_addr=0x1000, cons_len=64.
- Ping-pong: 3 jobs of 32 bytes, consumer delays cons_take -> jobs 1 and 2 fill buffers 0 and 1; job_ready=0 for job 3 until uf=01; job 3 then fills buffer 0; consumer sees cons_sel sequence 0,1,0.
- job_len=0 -> wpe, pe, pf pulse on consecutive cycles; no dma_req; cons_len=0.
- job_len=40000 -> dma_beats=4096, len_err=1, cons_len=32768.
- Reset asserted mid-F_DATA after 3 of 8 beats -> next cycle all outputs 0; later beats produce no wr_en; a new job starts on buffer 0.
- cons_take with cons_ready=0, and cons_done while shadow not USE -> no ue or uf pulse, no state change.
